// File: rtl/traceback_decoder_pkg.sv
// Shared constants and types for the traceback packet decoder.
// Packet encodings match the traceback unit; widths derive from SEQ_LENGTH.
package traceback_decoder_pkg;

  localparam int SEQ_LENGTH       = 32;
  localparam int SEQ_LENGTH_W     = $clog2(SEQ_LENGTH);
  localparam int DATA_PACKET_SIZE = 3;
  localparam int PKT_W            = DATA_PACKET_SIZE;
  localparam int RUN_W            = SEQ_LENGTH_W + 1;
  localparam int SPAN_W           = SEQ_LENGTH_W + 1;

  localparam logic [PKT_W-1:0] START_END_SIGNAL = 3'b111;
  localparam logic [PKT_W-1:0] LINE             = 3'b100;
  localparam logic [1:0]       TOP              = 2'b11;
  localparam logic [1:0]       LEFT             = 2'b01;

  typedef enum logic [1:0] {
    OP_DIAG = 2'b00,
    OP_LEFT = 2'b01,
    OP_TOP  = 2'b11
  } tb_op_e;

  typedef enum logic [1:0] {
    TB_IDLE,
    TB_RUN,
    TB_TERM
  } tb_state_e;

  // Both 00 and 10 are diagonal moves; they collapse to one op code.
  function automatic tb_op_e decode_move(input logic [1:0] mv);
    case (mv)
      TOP:     return OP_TOP;
      LEFT:    return OP_LEFT;
      default: return OP_DIAG;
    endcase
  endfunction

endpackage

// File: rtl/traceback_decoder_out_reg.sv
// One-entry output register for run-length records.
// Latency: loaded record is visible the cycle after load.
// Backpressure: in_rdy is low while full and the consumer is stalling.
module traceback_decoder_out_reg
  import traceback_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [1:0]        in_op,
  input  logic [RUN_W-1:0]  in_len,
  input  logic              in_last,
  input  logic              in_zero,
  input  logic [SPAN_W-1:0] in_row,
  input  logic [SPAN_W-1:0] in_col,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [1:0]        out_op,
  output logic [RUN_W-1:0]  out_len,
  output logic              out_last,
  output logic              out_zero,
  output logic [SPAN_W-1:0] out_row,
  output logic [SPAN_W-1:0] out_col
);

  // Draining and refilling in the same cycle is allowed, so no bubble.
  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_op   <= 2'b00;
      out_len  <= '0;
      out_last <= 1'b0;
      out_zero <= 1'b0;
      out_row  <= '0;
      out_col  <= '0;
    end else if (in_vld) begin
      out_vld  <= 1'b1;
      out_op   <= in_op;
      out_len  <= in_len;
      out_last <= in_last;
      out_zero <= in_zero;
      out_row  <= in_row;
      out_col  <= in_col;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/traceback_decoder.sv
// Turns framed traceback move packets into run-length (op, len) records plus spans.
// Latency: record registered on the edge accepting the closing packet, valid next cycle.
// Backpressure: pkt_ready_o follows the output register; full and stalled holds input.
module traceback_decoder
  import traceback_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PKT_W-1:0]  pkt_i,
  input  logic              pkt_valid_i,
  output logic              pkt_ready_o,
  output logic [1:0]        op_o,
  output logic [RUN_W-1:0]  run_len_o,
  output logic              last_o,
  output logic              zero_term_o,
  output logic [SPAN_W-1:0] row_span_o,
  output logic [SPAN_W-1:0] col_span_o,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [RUN_W-1:0]  RUN_MAX  = {RUN_W{1'b1}};
  localparam logic [SPAN_W-1:0] SPAN_MAX = {SPAN_W{1'b1}};

  tb_state_e         state_q, state_d;
  tb_op_e            cur_op_q, cur_op_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SPAN_W-1:0] row_q, row_d, col_q, col_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic   accept, is_marker, is_line, is_move;
  tb_op_e mv_op;
  logic   ld_vld, ld_last;

  assign accept    = pkt_valid_i && pkt_ready_o;
  assign is_marker = (pkt_i == START_END_SIGNAL);
  assign is_line   = (pkt_i == LINE);
  assign is_move   = !pkt_i[2];
  assign mv_op     = decode_move(pkt_i[1:0]);

  always_comb begin
    state_d  = state_q;
    cur_op_d = cur_op_q;
    run_d    = run_q;
    row_d    = row_q;
    col_d    = col_q;
    zero_d   = zero_q;
    err_d    = err_q;
    ld_vld   = 1'b0;
    ld_last  = 1'b0;
    if (accept) begin
      case (state_q)
        TB_IDLE: begin
          if (is_marker) begin
            state_d  = TB_RUN;
            cur_op_d = OP_DIAG;
            run_d    = '0;
            row_d    = '0;
            col_d    = '0;
            zero_d   = 1'b0;
            err_d    = 1'b0;
          end
        end
        TB_RUN: begin
          if (is_move) begin
            if (mv_op != OP_LEFT && row_q != SPAN_MAX) row_d = row_q + 1'b1;
            if (mv_op != OP_TOP && col_q != SPAN_MAX)  col_d = col_q + 1'b1;
            // A fresh frame has run 0 with op DIAG, so a leading DIAG just extends it.
            if (mv_op == cur_op_q && run_q != RUN_MAX) begin
              run_d = run_q + 1'b1;
            end else begin
              ld_vld   = (run_q != '0);
              cur_op_d = mv_op;
              run_d    = {{(RUN_W-1){1'b0}}, 1'b1};
            end
          end else if (is_line) begin
            zero_d  = 1'b1;
            state_d = TB_TERM;
          end else if (is_marker) begin
            ld_vld  = 1'b1;
            ld_last = 1'b1;
            state_d = TB_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = TB_IDLE;
          end
        end
        TB_TERM: begin
          if (is_marker) begin
            ld_vld  = 1'b1;
            ld_last = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
          state_d = TB_IDLE;
        end
        default: state_d = TB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TB_IDLE;
      cur_op_q <= OP_DIAG;
      run_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_op_q <= cur_op_d;
      run_q    <= run_d;
      row_q    <= row_d;
      col_q    <= col_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  traceback_decoder_out_reg u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (ld_vld),
    .in_rdy   (pkt_ready_o),
    .in_op    (cur_op_q),
    .in_len   (run_q),
    .in_last  (ld_last),
    .in_zero  (zero_q),
    .in_row   (row_q),
    .in_col   (col_q),
    .out_vld  (op_valid_o),
    .out_rdy  (op_ready_i),
    .out_op   (op_o),
    .out_len  (run_len_o),
    .out_last (last_o),
    .out_zero (zero_term_o),
    .out_row  (row_span_o),
    .out_col  (col_span_o)
  );

  assign err_o  = err_q;
  assign busy_o = (state_q != TB_IDLE);

endmodule

// File: tb/tb_traceback_decoder.sv
// Randomized and directed bench for traceback_decoder against a frame-level
// run-length model of the packet stream.
module tb_traceback_decoder;
  import traceback_decoder_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] len;
    logic       last;
    logic       zero;
    logic [5:0] row;
    logic [5:0] col;
  } rec_s;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PKT_W-1:0]  pkt_i;
  logic              pkt_valid_i;
  logic              pkt_ready_o;
  logic [1:0]        op_o;
  logic [RUN_W-1:0]  run_len_o;
  logic              last_o;
  logic              zero_term_o;
  logic [SPAN_W-1:0] row_span_o;
  logic [SPAN_W-1:0] col_span_o;
  logic              op_valid_o;
  logic              op_ready_i;
  logic              err_o;
  logic              busy_o;

  traceback_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_i       (pkt_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .op_o        (op_o),
    .run_len_o   (run_len_o),
    .last_o      (last_o),
    .zero_term_o (zero_term_o),
    .row_span_o  (row_span_o),
    .col_span_o  (col_span_o),
    .op_valid_o  (op_valid_o),
    .op_ready_i  (op_ready_i),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [2:0] stim_q[$];
  rec_s       exp_q[$];
  rec_s       got_q[$];
  bit         model_err  = 1'b0;
  bit         model_open = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level reference: collect each frame's moves, then run-length encode them.
  task automatic model_stream();
    int i, n, outcome, nrow, ncol, last_k;
    logic [2:0] p;
    int mv[$];
    int r_op[$];
    int r_len[$];
    rec_s r;
    exp_q.delete();
    model_open = 1'b0;
    i = 0;
    n = stim_q.size();
    while (i < n) begin
      p = stim_q[i];
      i++;
      if (p != 3'b111) continue;
      model_err = 1'b0;
      mv.delete();
      outcome = 0;  // 0 open, 1 end, 2 error, 3 end after zero cell
      while (i < n && outcome == 0) begin
        p = stim_q[i];
        i++;
        if (!p[2]) mv.push_back(p[1:0] == 2'b11 ? 3 : (p[1:0] == 2'b01 ? 1 : 0));
        else if (p == 3'b111) outcome = 1;
        else if (p == 3'b100) begin
          if (i < n) begin
            outcome = (stim_q[i] == 3'b111) ? 3 : 2;
            i++;
          end else begin
            outcome = 4;
          end
        end else outcome = 2;
      end
      r_op.delete();
      r_len.delete();
      nrow = 0;
      ncol = 0;
      foreach (mv[k]) begin
        if (mv[k] != 1) nrow++;
        if (mv[k] != 3) ncol++;
        if (r_op.size() > 0 && r_op[r_op.size()-1] == mv[k] && r_len[r_len.size()-1] < 63)
          r_len[r_len.size()-1] = r_len[r_len.size()-1] + 1;
        else begin
          r_op.push_back(mv[k]);
          r_len.push_back(1);
        end
      end
      for (int k = 0; k < r_op.size() - 1; k++) begin
        r = '0;
        r.op  = 2'(r_op[k]);
        r.len = 6'(r_len[k]);
        exp_q.push_back(r);
      end
      if (outcome == 1 || outcome == 3) begin
        r = '0;
        last_k = r_op.size() - 1;
        if (last_k >= 0) begin
          r.op  = 2'(r_op[last_k]);
          r.len = 6'(r_len[last_k]);
        end
        r.last = 1'b1;
        r.zero = (outcome == 3);
        r.row  = 6'((nrow > 63) ? 63 : nrow);
        r.col  = 6'((ncol > 63) ? 63 : ncol);
        exp_q.push_back(r);
      end else if (outcome == 2) begin
        model_err = 1'b1;
      end else begin
        model_open = 1'b1;
      end
    end
  endtask

  // mode 0: always ready, 1: random valid/ready, 2: stall the first record 5 cycles
  task automatic run_stream(input int mode);
    int   idx, cyc, quiet, stall_left;
    bit   held_vld;
    rec_s cur, held;
    idx = 0; cyc = 0; quiet = 0; stall_left = 5; held_vld = 1'b0; held = '0;
    got_q.delete();
    while (!(idx >= stim_q.size() && quiet >= 3)) begin
      @(negedge clk);
      case (mode)
        1: op_ready_i = (($urandom % 3) != 0);
        2: begin
          if (op_valid_o && stall_left > 0) begin
            op_ready_i = 1'b0;
            stall_left--;
          end else op_ready_i = 1'b1;
        end
        default: op_ready_i = 1'b1;
      endcase
      if (idx < stim_q.size() && (mode != 1 || ($urandom % 4) != 0)) begin
        pkt_valid_i = 1'b1;
        pkt_i       = stim_q[idx];
      end else begin
        pkt_valid_i = 1'b0;
        pkt_i       = 3'($urandom);
      end
      #1;
      cur = {op_o, run_len_o, last_o, zero_term_o, row_span_o, col_span_o};
      if (op_valid_o && !op_ready_i) begin
        chk("stall_pkt_ready", {31'd0, pkt_ready_o}, 32'd0);
        if (held_vld) chk("stall_hold", 32'(cur), 32'(held));
        held     = cur;
        held_vld = 1'b1;
      end else held_vld = 1'b0;
      if (op_valid_o && op_ready_i) got_q.push_back(cur);
      if (pkt_valid_i && pkt_ready_o) idx++;
      quiet = (idx >= stim_q.size() && !op_valid_o) ? quiet + 1 : 0;
      cyc++;
      if (cyc > 5000) begin
        chk("stream_timeout", 32'(idx), 32'(stim_q.size()));
        break;
      end
    end
    @(negedge clk);
    pkt_valid_i = 1'b0;
    op_ready_i  = 1'b1;
  endtask

  task automatic check_stream(input string name);
    int m;
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk({name, "_op"},   32'(got_q[k].op),   32'(exp_q[k].op));
      chk({name, "_len"},  32'(got_q[k].len),  32'(exp_q[k].len));
      chk({name, "_last"}, 32'(got_q[k].last), 32'(exp_q[k].last));
      if (exp_q[k].last) begin
        chk({name, "_zero"}, 32'(got_q[k].zero), 32'(exp_q[k].zero));
        chk({name, "_row"},  32'(got_q[k].row),  32'(exp_q[k].row));
        chk({name, "_col"},  32'(got_q[k].col),  32'(exp_q[k].col));
      end
    end
    chk({name, "_err"},  {31'd0, err_o},  {31'd0, model_err});
    chk({name, "_busy"}, {31'd0, busy_o}, {31'd0, model_open});
  endtask

  task automatic directed(input string name, input int mode);
    model_stream();
    run_stream(mode);
    check_stream(name);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_valid"}, {31'd0, op_valid_o}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy_o},     32'd0);
    chk({name, "_err"},   {31'd0, err_o},      32'd0);
    chk({name, "_rec"},   32'({op_o, run_len_o, last_o, zero_term_o, row_span_o, col_span_o}), 32'd0);
  endtask

  task automatic gen_frames(input int nf);
    int kind, nm, cls, e;
    for (int f = 0; f < nf; f++) begin
      kind = $urandom % 10;
      if (kind == 0) begin
        stim_q.push_back(3'($urandom_range(0, 6)));
      end else begin
        stim_q.push_back(3'b111);
        nm  = (kind == 9) ? 64 + ($urandom % 10) : ($urandom % 20);
        cls = $urandom % 3;
        for (int m = 0; m < nm; m++) begin
          if (kind != 9 && ($urandom % 4) == 0) cls = $urandom % 3;
          if (cls == 0)      stim_q.push_back((($urandom % 2) != 0) ? 3'b010 : 3'b000);
          else if (cls == 1) stim_q.push_back(3'b001);
          else               stim_q.push_back(3'b011);
        end
        e = $urandom % 8;
        if (e == 0) stim_q.push_back((($urandom % 2) != 0) ? 3'b101 : 3'b110);
        else if (e == 1) begin
          stim_q.push_back(3'b100);
          stim_q.push_back(3'b000);
        end else if (e < 4) begin
          stim_q.push_back(3'b100);
          stim_q.push_back(3'b111);
        end else stim_q.push_back(3'b111);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pkt_i = '0; pkt_valid_i = 1'b0; op_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    stim_q = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b001, 3'b111};
    directed("mixed", 0);

    stim_q = '{3'b111, 3'b000, 3'b010, 3'b100, 3'b111};
    directed("diag_zero", 0);

    stim_q = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b001, 3'b111};
    directed("backpressure", 2);

    stim_q = '{3'b111, 3'b000, 3'b110};
    directed("illegal", 0);
    stim_q = '{3'b000};
    directed("idle_drop", 0);
    stim_q = '{3'b111, 3'b001, 3'b111};
    directed("err_clear", 0);

    stim_q = '{3'b111, 3'b111};
    directed("empty", 0);

    stim_q.delete();
    stim_q.push_back(3'b111);
    for (int k = 0; k < 32; k++) stim_q.push_back(3'b000);
    stim_q.push_back(3'b111);
    directed("full_len", 0);

    stim_q = '{3'b111, 3'b000, 3'b000};
    directed("pre_reset", 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stim_q = '{3'b111, 3'b001, 3'b111};
    directed("post_reset", 0);

    for (int s = 0; s < 10; s++) begin
      stim_q.delete();
      gen_frames(5);
      stim_q.push_back(3'b111);
      stim_q.push_back(3'b111);
      directed("random", 1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
